msftdvip_dma_xfer_seq: RTL and testbench

MSFTDVIP_DMA_XFER_SEQ -- requirements
Module: msftDvIp_dma_xfer_seq

---
 rtl/msftDvIp_dma_pkg.sv | 36 +++
 rtl/msftDvIp_dma_beat_gen.sv | 57 +++++
 rtl/msftdvip_dma_xfer_seq.sv | 165 ++++++++++++++++
 tb/tb_msftdvip_dma_xfer_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msftDvIp_dma_pkg.sv
// Shared state encoding, beat-size encodings and size-select rules for the
// DMA transfer sequencer.
package msftDvIp_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } dma_state_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } dma_size_e;

  // Largest naturally aligned beat that does not overrun the remaining count.
  function automatic dma_size_e sel_size(input logic [1:0] addr_lo,
                                         input logic       rem_ge4,
                                         input logic       rem_ge2);
    if (addr_lo == 2'b00 && rem_ge4) return SIZE_WORD;
    if (!addr_lo[0] && rem_ge2)      return SIZE_HALF;
    return SIZE_BYTE;
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      3'd2:    return 3'd4;
      3'd1:    return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/msftDvIp_dma_beat_gen.sv
// One command channel's address/remaining-count tracker; presents the size of
// the next beat and advances by that many bytes on each accepted command.
module msftDvIp_dma_beat_gen
  import msftDvIp_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [31:0]          addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 adv_i,
  output logic [31:0]          addr_o,
  output logic [2:0]           size_o,
  output logic [2:0]           bytes_o,
  output logic                 pending_o
);

  logic [31:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  dma_size_e            size;
  logic [2:0]           bytes;

  assign size  = sel_size(addr_q[1:0], rem_q >= LEN_WIDTH'(4), rem_q >= LEN_WIDTH'(2));
  assign bytes = size_bytes(size);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = addr_i;
      rem_d  = len_i;
    end else if (adv_i) begin
      addr_d = addr_q + 32'(bytes);
      rem_d  = rem_q - LEN_WIDTH'(bytes);
    end
  end

  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o    = addr_q;
  assign size_o    = size;
  assign bytes_o   = bytes;
  assign pending_o = (rem_q != '0);

endmodule

// File: rtl/msftdvip_dma_xfer_seq.sv
// DMA transfer sequencer: splits a byte copy into aligned read/write beats,
// throttled by FIFO credit. Optional abort_i path under DMA_XFER_SEQ_ABORT_EN.
module msftdvip_dma_xfer_seq
  import msftDvIp_dma_pkg::*;
#(
  parameter int FIFO_BYTES = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef DMA_XFER_SEQ_ABORT_EN
  input  logic                 abort_i,
`endif
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 rd_cmd_valid_o,
  input  logic                 rd_cmd_ready_i,
  output logic [31:0]          rd_addr_o,
  output logic [2:0]           rd_size_o,
  input  logic                 rd_done_i,
  input  logic [2:0]           rd_done_size_i,
  output logic                 wr_cmd_valid_o,
  input  logic                 wr_cmd_ready_i,
  output logic [31:0]          wr_addr_o,
  output logic [2:0]           wr_size_o,
  input  logic                 rd_err_i,
  input  logic                 wr_err_i,
  output logic                 fifo_rstn_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int              CW       = $clog2(FIFO_BYTES) + 1;
  localparam logic [CW-1:0]   FIFO_CAP = CW'(FIFO_BYTES);

  dma_state_e    state_q;
  logic          busy_q, done_q, err_q, fifo_rstn_q;
  logic [CW-1:0] outst_q, outst_d, landed_q, landed_d, credit;
  logic [CW-1:0] rd_add, wr_sub, land_add;
  logic          can_start, launch, in_run, rd_acc, wr_acc;
  logic [2:0]    rd_bytes, wr_bytes;
  logic          rd_pend, wr_pend;

  assign can_start = start_i && (state_q == ST_IDLE || state_q == ST_ERR);
  assign launch    = can_start && (len_i != '0);
  assign in_run    = (state_q == ST_RUN);

  msftDvIp_dma_beat_gen #(.LEN_WIDTH(LEN_WIDTH)) u_rd_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (launch),
    .addr_i   (src_addr_i),
    .len_i    (len_i),
    .adv_i    (rd_acc),
    .addr_o   (rd_addr_o),
    .size_o   (rd_size_o),
    .bytes_o  (rd_bytes),
    .pending_o(rd_pend)
  );

  msftDvIp_dma_beat_gen #(.LEN_WIDTH(LEN_WIDTH)) u_wr_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (launch),
    .addr_i   (dst_addr_i),
    .len_i    (len_i),
    .adv_i    (wr_acc),
    .addr_o   (wr_addr_o),
    .size_o   (wr_size_o),
    .bytes_o  (wr_bytes),
    .pending_o(wr_pend)
  );

  // Credit counts bytes the FIFO can still accept; landed counts bytes ready to write.
  assign credit         = FIFO_CAP - outst_q;
  assign rd_cmd_valid_o = in_run && rd_pend && (credit >= CW'(rd_bytes));
  assign wr_cmd_valid_o = in_run && wr_pend && (landed_q >= CW'(wr_bytes));
  assign rd_acc         = rd_cmd_valid_o && rd_cmd_ready_i;
  assign wr_acc         = wr_cmd_valid_o && wr_cmd_ready_i;

  assign rd_add   = rd_acc ? CW'(rd_bytes) : '0;
  assign wr_sub   = wr_acc ? CW'(wr_bytes) : '0;
  assign land_add = (in_run && rd_done_i) ? CW'(size_bytes(rd_done_size_i)) : '0;

  always_comb begin
    outst_d  = outst_q + rd_add - wr_sub;
    landed_d = landed_q + land_add - wr_sub;
    if (launch) begin
      outst_d  = '0;
      landed_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q  <= '0;
      landed_q <= '0;
    end else begin
      outst_q  <= outst_d;
      landed_q <= landed_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fifo_rstn_q <= 1'b1;
    end else begin
      done_q      <= 1'b0;
      fifo_rstn_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          // A start in ERR both clears the error and launches the new transfer.
          if (can_start) begin
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (launch) begin
              state_q     <= ST_CLR;
              fifo_rstn_q <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_CLR: state_q <= ST_RUN;
        ST_RUN: begin
          if (rd_err_i || wr_err_i) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
`ifdef DMA_XFER_SEQ_ABORT_EN
          end else if (abort_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            fifo_rstn_q <= 1'b0;
`endif
          end else if (!wr_pend) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rstn_o = fifo_rstn_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_msftdvip_dma_xfer_seq.sv
// Scoreboard bench for msftdvip_dma_xfer_seq: expected beats come from a
// byte-level model of the split rules; a monitor checks every accepted command.
module tb_msftdvip_dma_xfer_seq;

  localparam int FIFO_BYTES = 16;
  localparam int LEN_WIDTH  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_i = 1'b0;
  logic [31:0]          src_addr_i = '0;
  logic [31:0]          dst_addr_i = '0;
  logic [LEN_WIDTH-1:0] len_i = '0;
  logic                 rd_cmd_valid_o, wr_cmd_valid_o;
  logic                 rd_cmd_ready_i = 1'b0, wr_cmd_ready_i = 1'b0;
  logic [31:0]          rd_addr_o, wr_addr_o;
  logic [2:0]           rd_size_o, wr_size_o;
  logic                 rd_done_i = 1'b0;
  logic [2:0]           rd_done_size_i = '0;
  logic                 rd_err_i = 1'b0, wr_err_i = 1'b0;
  logic                 fifo_rstn_o, busy_o, done_o, err_o;
`ifdef DMA_XFER_SEQ_ABORT_EN
  logic                 abort_i = 1'b0;
`endif

  msftdvip_dma_xfer_seq #(.FIFO_BYTES(FIFO_BYTES), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
`ifdef DMA_XFER_SEQ_ABORT_EN
    .abort_i       (abort_i),
`endif
    .start_i       (start_i),
    .src_addr_i    (src_addr_i),
    .dst_addr_i    (dst_addr_i),
    .len_i         (len_i),
    .rd_cmd_valid_o(rd_cmd_valid_o),
    .rd_cmd_ready_i(rd_cmd_ready_i),
    .rd_addr_o     (rd_addr_o),
    .rd_size_o     (rd_size_o),
    .rd_done_i     (rd_done_i),
    .rd_done_size_i(rd_done_size_i),
    .wr_cmd_valid_o(wr_cmd_valid_o),
    .wr_cmd_ready_i(wr_cmd_ready_i),
    .wr_addr_o     (wr_addr_o),
    .wr_size_o     (wr_size_o),
    .rd_err_i      (rd_err_i),
    .wr_err_i      (wr_err_i),
    .fifo_rstn_o   (fifo_rstn_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [34:0] exp_rd_q[$];
  logic [34:0] exp_wr_q[$];
  int          pend_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          rd_acc = 0, wr_acc = 0;
  int          issued_b = 0, written_b = 0, landed_b = 0;
  int          rd_mode = 1, wr_mode = 1;   // 0: ready low, 1: ready high, 2: random
  bit          auto_done = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: largest aligned beat not exceeding the remaining bytes.
  task automatic gen_beats(input logic [31:0] a, input int n, input bit is_rd, output int cnt);
    logic [31:0] p = a;
    int          r = n;
    int          sz;
    cnt = 0;
    while (r > 0) begin
      if (p % 4 == 0 && r >= 4)      sz = 2;
      else if (p % 2 == 0 && r >= 2) sz = 1;
      else                           sz = 0;
      if (is_rd) exp_rd_q.push_back({p, 3'(sz)});
      else       exp_wr_q.push_back({p, 3'(sz)});
      p += 32'(1 << sz);
      r -= (1 << sz);
      cnt++;
    end
  endtask

  // Monitor: every accepted command is popped against the scoreboard.
  always @(negedge clk_i) begin
    logic [34:0] e;
    int          b;
    if (!rst_i) begin
      if (rd_cmd_valid_o && rd_cmd_ready_i) begin
        b = 1 << rd_size_o;
        if (exp_rd_q.size() == 0) check("rd_queue_nonempty", 64'(exp_rd_q.size()), 1);
        else begin
          e = exp_rd_q.pop_front();
          check("rd_cmd", {rd_addr_o, rd_size_o}, e);
        end
        check("credit_bound", 64'((issued_b - written_b + b) <= FIFO_BYTES), 1);
        issued_b += b;
        rd_acc++;
        pend_q.push_back(int'(rd_size_o));
      end
      if (wr_cmd_valid_o && wr_cmd_ready_i) begin
        b = 1 << wr_size_o;
        if (exp_wr_q.size() == 0) check("wr_queue_nonempty", 64'(exp_wr_q.size()), 1);
        else begin
          e = exp_wr_q.pop_front();
          check("wr_cmd", {wr_addr_o, wr_size_o}, e);
        end
        check("landed_bound", 64'((written_b + b) <= landed_b), 1);
        written_b += b;
        wr_acc++;
      end
      if (rd_done_i) landed_b += (1 << rd_done_size_i);
    end
  end

  // Downstream responder: read completions with random latency, ready patterns.
  always @(posedge clk_i) begin
    #1;
    if (auto_done && pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      rd_done_i      = 1'b1;
      rd_done_size_i = 3'(pend_q.pop_front());
    end else begin
      rd_done_i      = 1'b0;
      rd_done_size_i = 3'd0;
    end
    rd_cmd_ready_i = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
    wr_cmd_ready_i = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
  end

  task automatic flush();
    exp_rd_q.delete();
    exp_wr_q.delete();
    pend_q.delete();
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n,
                        output int nr, output int nw);
    gen_beats(s, n, 1'b1, nr);
    gen_beats(d, n, 1'b0, nw);
    issued_b  = 0;
    written_b = 0;
    landed_b  = 0;
    pend_q.delete();
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = LEN_WIDTH'(n);
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("launch_fifo_rstn", fifo_rstn_o, (n == 0));
    check("launch_busy", busy_o, 1);
  endtask

  task automatic wait_done(input string name, output int k);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!done_o && k < 3000);
    check(name, done_o, 1);
    @(negedge clk_i);
    check({name, "_after"}, {busy_o, done_o}, 2'b00);
  endtask

  task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                          input int n);
    int rd0 = rd_acc, wr0 = wr_acc, nr, nw, k;
    launch(s, d, n, nr, nw);
    wait_done(name, k);
    check({name, "_rd_count"}, 64'(rd_acc - rd0), 64'(nr));
    check({name, "_wr_count"}, 64'(wr_acc - wr0), 64'(nw));
    check({name, "_rd_left"}, 64'(exp_rd_q.size()), 0);
    check({name, "_wr_left"}, 64'(exp_wr_q.size()), 0);
  endtask

  initial begin
    int k, nr, nw, rd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outs", {rd_cmd_valid_o, wr_cmd_valid_o, done_o, err_o, busy_o, fifo_rstn_o},
          6'b000001);
    check("reset_addrs", {rd_addr_o, wr_addr_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_xfer("aligned", 32'h100, 32'h200, 8);
    run_xfer("unaligned", 32'h101, 32'h203, 7);

    // Zero length: done the cycle after start, no commands.
    rd0 = rd_acc;
    launch(32'h10, 32'h20, 0, nr, nw);
    wait_done("zero_len", k);
    check("zero_len_latency", 64'(k), 1);
    check("zero_len_no_cmds", 64'(rd_acc - rd0), 0);
    @(posedge clk_i); #1;

    // Credit stall: no completions, so only FIFO_BYTES worth of reads may issue.
    auto_done = 1'b0;
    rd0 = rd_acc;
    launch(32'h1000, 32'h2000, 32, nr, nw);
    repeat (30) @(negedge clk_i);
    check("stall_rd_count", 64'(rd_acc - rd0), 4);
    check("stall_valids", {rd_cmd_valid_o, wr_cmd_valid_o}, 2'b00);
    auto_done = 1'b1;
    wait_done("stall_done", k);
    check("stall_wr_left", 64'(exp_wr_q.size()), 0);
    @(posedge clk_i); #1;

    // Write backpressure: held command stays stable, reads cap at FIFO_BYTES.
    wr_mode = 0;
    launch(32'h9000, 32'hA000, 32, nr, nw);
    k = 0;
    while (!wr_cmd_valid_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {wr_cmd_valid_o, wr_addr_o, wr_size_o}, {1'b1, 32'hA000, 3'd2});
      @(negedge clk_i);
    end
    check("bp_outstanding", 64'(issued_b - written_b), 64'(FIFO_BYTES));
    check("bp_rd_valid", rd_cmd_valid_o, 0);
    @(posedge clk_i); #1;
    wr_mode = 2;
    wait_done("bp_done", k);
    @(posedge clk_i); #1;

    // Error mid-RUN, then a normal transfer from ERR.
    rd_mode = 1;
    wr_mode = 2;
    rd0 = rd_acc;
    launch(32'h3000, 32'h4000, 64, nr, nw);
    k = 0;
    while (rd_acc == rd0 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    check("err_in_run", 64'(rd_acc != rd0), 1);
    @(posedge clk_i); #1;
    wr_err_i = 1'b1;
    @(posedge clk_i); #1;
    wr_err_i = 1'b0;
    @(negedge clk_i);
    check("err_outs", {rd_cmd_valid_o, wr_cmd_valid_o, err_o, busy_o}, 4'b0011);
    repeat (3) @(negedge clk_i);
    check("err_hold", {rd_cmd_valid_o, wr_cmd_valid_o, err_o}, 3'b001);
    @(posedge clk_i); #1;
    flush();
    run_xfer("after_err", 32'h500, 32'h600, 4);
    check("after_err_flag", err_o, 0);

    // Reset mid-RUN abandons the transfer.
    rd_mode = 1;
    wr_mode = 1;
    rd0 = rd_acc;
    launch(32'h7000, 32'h8000, 48, nr, nw);
    k = 0;
    while (rd_acc == rd0 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_run_outs", {rd_cmd_valid_o, wr_cmd_valid_o, done_o, err_o, busy_o, fifo_rstn_o},
          6'b000001);
    check("rst_run_addrs", {rd_addr_o, wr_addr_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    flush();
    rd0 = rd_acc;
    repeat (5) @(negedge clk_i);
    check("rst_run_quiet", {rd_cmd_valid_o, wr_cmd_valid_o, busy_o, 32'(rd_acc - rd0)}, '0);
    @(posedge clk_i); #1;

    run_xfer("wrap", 32'hFFFF_FFFD, 32'hFFFF_FFFE, 9);

    for (int t = 0; t < 10; t++) begin
      rd_mode = $urandom_range(1, 2);
      wr_mode = $urandom_range(1, 2);
      run_xfer("random", $urandom(), $urandom(), $urandom_range(1, 40));
      @(posedge clk_i); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
